ghostbus_host_seq: RTL and testbench

- Bus-initiator end of the ghostbus register/RAM protocol: converts a valid/ready command stream into single-cycle write/read strobes on the ghostbus, so decoded host-accessible registers and RAMs can be exercised from any stream master (debug bridge, soft CPU, bench).
- Supports auto-incrementing bursts.
- Returns read data on a valid/ready response stream.
- Sits at the top of the hierarchy, driving the ghostbus address/data/strobe nets that fan out to all decoded modules.

---
 rtl/ghostbus_host_seq.sv | 179 +++++++++++++++++
 tb/tb_ghostbus_host_seq.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghostbus_host_seq.sv
`default_nettype none
// ============================================================================
// Module   : ghostbus_host_seq
// Purpose  : Bus-initiator end of the ghostbus register/RAM protocol. Turns a
//            valid/ready command stream into single-cycle gb_we / gb_re
//            strobes, auto-increments the address across bursts, and returns
//            read data on a valid/ready response stream.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            cmd_*               - burst command stream (we, start addr, len-1)
//            wr_*                - write data stream (consumed during WR only)
//            rsp_*               - read response stream (data, last-beat flag)
//            busy, done          - burst in progress / one-cycle completion
//            gb_*                - ghostbus address, data, strobes, read data
// Revision : 1.0 - initial release
// ============================================================================
module ghostbus_host_seq #(
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int LW     = 8,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_last,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_wdata,
    output logic          gb_we,
    output logic          gb_re,
    input  logic [DW-1:0] gb_rdata
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR       = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_RSP      = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [AW-1:0] c_ADDR_ONE = AW'(1);
    localparam logic [LW-1:0] c_CNT_ONE  = LW'(1);
    localparam logic [LW-1:0] c_CNT_ZERO = '0;
    localparam logic [2:0]    c_RD_LAT   = 3'(RD_LAT);
    localparam logic [2:0]    c_LAT_ONE  = 3'd1;

    state_t        r_state;
    logic [AW-1:0] r_addr;    // address of the next beat to be issued
    logic [LW-1:0] r_cnt;     // beats remaining after the current one
    logic [2:0]    r_lat;     // read-latency countdown
    logic          r_wr_fin;  // final write strobe is on the bus this cycle

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_lat     <= '0;
            r_wr_fin  <= 1'b0;
            cmd_ready <= 1'b1;
            wr_ready  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            done      <= 1'b0;
            gb_addr   <= '0;
            gb_wdata  <= '0;
            gb_we     <= 1'b0;
            gb_re     <= 1'b0;
        end else begin
            // Strobes and done are single-cycle pulses unless re-armed below.
            gb_we <= 1'b0;
            gb_re <= 1'b0;
            done  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        gb_addr   <= cmd_addr;
                        r_cnt     <= cmd_len;
                        if (cmd_we) begin
                            r_addr   <= cmd_addr;
                            wr_ready <= 1'b1;
                            r_state  <= S_WR;
                        end else begin
                            // First read strobe goes out in the RD_ISSUE cycle.
                            r_addr  <= cmd_addr + c_ADDR_ONE;
                            gb_re   <= 1'b1;
                            r_state <= S_RD_ISSUE;
                        end
                    end
                end

                S_WR: begin
                    if (r_wr_fin) begin
                        // Last strobe has been on the bus for its cycle.
                        r_wr_fin <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (wr_valid && wr_ready) begin
                        gb_we    <= 1'b1;
                        gb_wdata <= wr_data;
                        gb_addr  <= r_addr;
                        r_addr   <= r_addr + c_ADDR_ONE;
                        if (r_cnt == c_CNT_ZERO) begin
                            wr_ready <= 1'b0;
                            r_wr_fin <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - c_CNT_ONE;
                        end
                    end
                end

                S_RD_ISSUE: begin
                    r_lat   <= c_RD_LAT;
                    r_state <= S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    r_lat <= r_lat - c_LAT_ONE;
                    if (r_lat == c_LAT_ONE) begin
                        rsp_data  <= gb_rdata;
                        rsp_valid <= 1'b1;
                        rsp_last  <= (r_cnt == c_CNT_ZERO);
                        r_state   <= S_RSP;
                    end
                end

                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        if (r_cnt == c_CNT_ZERO) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            // Next read issues only after the previous response drains.
                            r_cnt   <= r_cnt - c_CNT_ONE;
                            gb_addr <= r_addr;
                            r_addr  <= r_addr + c_ADDR_ONE;
                            gb_re   <= 1'b1;
                            r_state <= S_RD_ISSUE;
                        end
                    end
                end

                S_DONE: begin
                    cmd_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end

                default: begin
                    cmd_ready <= 1'b1;
                    wr_ready  <= 1'b0;
                    rsp_valid <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ghostbus_host_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ghostbus_host_seq
// Purpose  : Self-checking bench for ghostbus_host_seq. A transaction-level
//            model (beat lists, scheduled event cycles, memory function)
//            predicts every output each cycle; directed scenarios add literal
//            expectations, followed by randomized bursts with random resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ghostbus_host_seq;
    localparam int AW     = 24;
    localparam int DW     = 32;
    localparam int LW     = 8;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rsp_valid, rsp_ready, rsp_last;
    logic [DW-1:0] rsp_data;
    logic          busy, done;
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_wdata, gb_rdata;
    logic          gb_we, gb_re;

    always #5 clk = ~clk;

    ghostbus_host_seq #(.AW(AW), .DW(DW), .LW(LW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .busy(busy), .done(done),
        .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_we(gb_we), .gb_re(gb_re),
        .gb_rdata(gb_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Behavioural model: burst bookkeeping plus the cycle each event is due.
    bit            m_busy, m_is_wr, m_show, m_rlast, pend_last;
    logic [AW-1:0] m_addr, we_addr, re_addr;
    logic [DW-1:0] we_data, m_rdata, pend_data;
    int            m_left, we_at, re_at, rsp_at, done_at, idle_at;

    // Memory read-port history, used to return data RD_LAT cycles later.
    bit            h_re   [16];
    logic [AW-1:0] h_addr [16];

    // Stimulus policy knobs.
    int            pol_wr, pol_rsp, stall_beat, stall_left;
    bit            fix_wdata;
    logic [DW-1:0] fix_val;

    // Observation logs for directed literal checks.
    logic [AW-1:0] log_we_addr[$];
    logic [DW-1:0] log_we_data[$];
    logic [AW-1:0] log_re_addr[$];
    int            log_re_cyc[$];
    logic [DW-1:0] log_rsp_data[$];
    bit            log_rsp_last[$];
    int            done_cnt, done_cyc, first_rv_cyc, hs_cyc, last_we_cyc;
    bit            hs_cmd;

    logic [DW-1:0] exp_rd [4] = '{32'h0000A5E5, 32'h0000A5E4, 32'h0000A5E7, 32'h0000A5E6};

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return DW'(a) ^ 32'h0000A5A5;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_busy = 0; m_is_wr = 0; m_show = 0; m_left = 0;
        we_at = -1; re_at = -1; rsp_at = -1; done_at = -1; idle_at = -1;
    endtask

    task automatic clear_logs();
        log_we_addr.delete(); log_we_data.delete(); log_re_addr.delete();
        log_re_cyc.delete(); log_rsp_data.delete(); log_rsp_last.delete();
        done_cnt = 0; done_cyc = -1; first_rv_cyc = -1; hs_cyc = -1; last_we_cyc = -1;
    endtask

    // One clock cycle: drive inputs for the current cycle, compare outputs,
    // advance the model, then move to the next falling edge.
    task automatic step();
        if (cyc >= RD_LAT && h_re[(cyc - RD_LAT) % 16]) gb_rdata = mem_f(h_addr[(cyc - RD_LAT) % 16]);
        else gb_rdata = $urandom;
        h_re[cyc % 16]   = gb_re;
        h_addr[cyc % 16] = gb_addr;

        case (pol_wr)
            0:       wr_valid = 1'b1;
            1:       wr_valid = (cyc % 2 == 0);
            default: wr_valid = 1'($urandom_range(0, 1));
        endcase
        wr_data = fix_wdata ? fix_val : $urandom;
        if (rsp_valid && stall_left > 0 && log_rsp_data.size() == stall_beat) begin
            rsp_ready = 1'b0;
            stall_left--;
        end else begin
            rsp_ready = (pol_rsp == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end

        if (cyc == rsp_at) begin m_show = 1; m_rdata = pend_data; m_rlast = pend_last; rsp_at = -1; end
        if (cyc == idle_at) begin m_busy = 0; idle_at = -1; end

        chk("busy", busy, m_busy);
        chk("cmd_ready", cmd_ready, !m_busy);
        chk("wr_ready", wr_ready, m_busy && m_is_wr && m_left > 0);
        chk("gb_we", gb_we, cyc == we_at);
        if (cyc == we_at) begin
            chk("gb_we_addr", gb_addr, we_addr);
            chk("gb_wdata", gb_wdata, we_data);
        end
        chk("gb_re", gb_re, cyc == re_at);
        if (cyc == re_at) chk("gb_re_addr", gb_addr, re_addr);
        chk("rsp_valid", rsp_valid, m_show);
        if (m_show) begin
            chk("rsp_data", rsp_data, m_rdata);
            chk("rsp_last", rsp_last, m_rlast);
        end
        chk("done", done, cyc == done_at);

        hs_cmd = cmd_valid && cmd_ready && !rst;
        if (hs_cmd) hs_cyc = cyc;
        if (gb_we) begin log_we_addr.push_back(gb_addr); log_we_data.push_back(gb_wdata); last_we_cyc = cyc; end
        if (gb_re) begin log_re_addr.push_back(gb_addr); log_re_cyc.push_back(cyc); end
        if (rsp_valid && first_rv_cyc < 0) first_rv_cyc = cyc;
        if (rsp_valid && rsp_ready && !rst) begin log_rsp_data.push_back(rsp_data); log_rsp_last.push_back(rsp_last); end
        if (done) begin done_cnt++; if (done_cnt == 1) done_cyc = cyc; end

        if (rst) begin
            model_reset();
        end else begin
            if (cyc == re_at) begin
                rsp_at    = cyc + RD_LAT + 1;
                pend_data = mem_f(re_addr);
                pend_last = (m_left == 1);
            end
            if (!m_busy) begin
                if (cmd_valid) begin
                    m_busy = 1; m_is_wr = cmd_we; m_addr = cmd_addr; m_left = int'(cmd_len) + 1;
                    if (!cmd_we) begin re_at = cyc + 1; re_addr = cmd_addr; end
                end
            end else if (m_is_wr) begin
                if (m_left > 0 && wr_valid) begin
                    we_at = cyc + 1; we_addr = m_addr; we_data = wr_data;
                    m_addr = m_addr + AW'(1);
                    m_left--;
                    if (m_left == 0) begin done_at = cyc + 2; idle_at = cyc + 3; end
                end
            end else if (m_show && rsp_ready) begin
                m_show = 0;
                m_left--;
                if (m_left > 0) begin re_addr = re_addr + AW'(1); re_at = cyc + 1; end
                else begin done_at = cyc + 1; idle_at = cyc + 2; end
            end
        end

        cyc++;
        @(negedge clk);
    endtask

    task automatic issue_cmd(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        bit ok = 0;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len;
        for (int i = 0; i < 50; i++) begin
            step();
            if (hs_cmd) begin ok = 1; break; end
        end
        cmd_valid = 1'b0;
        chk("cmd_accepted", ok, 1'b1);
    endtask

    task automatic wait_idle(input int budget, input bit allow_rst);
        for (int i = 0; i < budget; i++) begin
            rst = allow_rst && ($urandom_range(0, 59) == 0);
            step();
            rst = 1'b0;
            if (!m_busy) break;
        end
        rst = 1'b0;
        chk("burst_completes", m_busy, 1'b0);
    endtask

    initial begin
        int hs2;
        bit seen;
        rst = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 0; wr_data = '0; rsp_ready = 0; gb_rdata = '0;
        pol_wr = 0; pol_rsp = 0; stall_beat = -1; stall_left = 0; fix_wdata = 0; fix_val = '0;
        for (int i = 0; i < 16; i++) begin h_re[i] = 0; h_addr[i] = '0; end
        model_reset();
        clear_logs();
        repeat (3) @(negedge clk);

        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_last", rsp_last, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_strobes", {gb_we, gb_re}, 2'b00);
        chk("rst_gb_addr", gb_addr, 24'h0);
        chk("rst_gb_wdata", gb_wdata, 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        rst = 1'b0;
        repeat (2) step();

        // Single write
        clear_logs(); fix_wdata = 1; fix_val = 32'hDEADBEEF;
        issue_cmd(1'b1, 24'h000010, 8'd0);
        wait_idle(40, 1'b0);
        chk("wr1_count", log_we_addr.size(), 1);
        if (log_we_addr.size() > 0) begin
            chk("wr1_addr", log_we_addr[0], 24'h000010);
            chk("wr1_data", log_we_data[0], 32'hDEADBEEF);
        end
        chk("wr1_done_latency", done_cyc - hs_cyc, 3);
        chk("wr1_done_count", done_cnt, 1);
        step();
        chk("wr1_cmd_ready_back", cmd_ready, 1'b1);
        fix_wdata = 0;

        // Read burst, then the same burst with response backpressure on beat 1
        for (int pass = 0; pass < 2; pass++) begin
            clear_logs();
            if (pass == 1) begin stall_beat = 1; stall_left = 5; end
            issue_cmd(1'b0, 24'h000040, 8'd3);
            wait_idle(120, 1'b0);
            chk("rd_rsp_count", log_rsp_data.size(), 4);
            chk("rd_re_count", log_re_addr.size(), 4);
            chk("rd_first_latency", first_rv_cyc - hs_cyc, RD_LAT + 2);
            chk("rd_done_count", done_cnt, 1);
            for (int i = 0; i < 4; i++) begin
                if (i < log_rsp_data.size()) begin
                    chk("rd_data", log_rsp_data[i], exp_rd[i]);
                    chk("rd_last", log_rsp_last[i], i == 3);
                end
                if (i < log_re_addr.size()) chk("rd_re_addr", log_re_addr[i], 24'h40 + AW'(i));
                if (i > 0 && i < log_re_cyc.size()) chk("rd_re_gap", (log_re_cyc[i] - log_re_cyc[i-1]) >= 4, 1'b1);
            end
            stall_beat = -1; stall_left = 0;
        end

        // Write burst across the address wrap with gapped write data
        clear_logs(); pol_wr = 1;
        issue_cmd(1'b1, 24'hFFFFFE, 8'd2);
        wait_idle(60, 1'b0);
        chk("wrap_count", log_we_addr.size(), 3);
        if (log_we_addr.size() == 3) begin
            chk("wrap_addr0", log_we_addr[0], 24'hFFFFFE);
            chk("wrap_addr1", log_we_addr[1], 24'hFFFFFF);
            chk("wrap_addr2", log_we_addr[2], 24'h000000);
        end
        chk("wrap_no_re", log_re_addr.size(), 0);
        pol_wr = 0;

        // Maximum-length write burst
        clear_logs();
        issue_cmd(1'b1, 24'hFFFF80, 8'hFF);
        wait_idle(600, 1'b0);
        chk("max_count", log_we_addr.size(), 256);
        if (log_we_addr.size() == 256) chk("max_last_addr", log_we_addr[255], 24'h00007F);

        // Reset during RD_WAIT of beat 2 of an 8-beat read
        clear_logs(); seen = 0;
        issue_cmd(1'b0, 24'h000100, 8'd7);
        for (int i = 0; i < 60; i++) begin
            step();
            if (log_re_addr.size() == 2) begin seen = 1; break; end
        end
        chk("rstmid_reached_beat2", seen, 1'b1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_rsp_valid", rsp_valid, 1'b0);
        chk("rstmid_cmd_ready", cmd_ready, 1'b1);
        chk("rstmid_done", done, 1'b0);
        repeat (6) step();
        chk("rstmid_no_done", done_cnt, 0);
        chk("rstmid_rsp_count", log_rsp_data.size(), 1);
        clear_logs();
        issue_cmd(1'b0, 24'h000200, 8'd0);
        wait_idle(40, 1'b0);
        chk("rstmid_next_count", log_rsp_data.size(), 1);
        if (log_rsp_data.size() == 1) chk("rstmid_next_data", log_rsp_data[0], 32'h0000A7A5);

        // Second command held valid during a write burst
        clear_logs();
        issue_cmd(1'b1, 24'h000300, 8'd3);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 24'h000400; cmd_len = 8'd1;
        hs2 = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (hs_cmd) begin hs2 = hs_cyc; break; end
        end
        cmd_valid = 1'b0;
        chk("busy_cmd_accept_cycle", hs2 - done_cyc, 1);
        chk("busy_first_done", done_cnt, 1);
        wait_idle(60, 1'b0);
        if (log_re_cyc.size() > 0) chk("busy_no_overlap", log_re_cyc[0] > last_we_cyc, 1'b1);
        chk("busy_re_count", log_re_addr.size(), 2);

        // Randomized bursts with random backpressure, gaps and resets
        pol_wr = 2; pol_rsp = 1;
        for (int k = 0; k < 40; k++) begin
            logic [AW-1:0] a;
            a = (k % 4 == 0) ? (24'hFFFFFC + AW'($urandom_range(0, 3))) : AW'($urandom);
            issue_cmd(1'($urandom_range(0, 1)), a, LW'($urandom_range(0, 5)));
            wait_idle(400, 1'b1);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
